// File: rtl/rst_clk_seq.sv
// rst_clk_seq: reset sequencer and per-channel tick generator.
//
// After rst (or soft_rst_req) every channel reset is held for HOLD_CYC edges.
// The channel resets are then released one at a time, STAGGER_CYC edges apart.
// Each released channel runs a divider that emits a one-cycle tick every
// max(div_cfg_i, 1) cycles.
//
// Optional build macro: SEQ_TICK_CNT_EN adds tick_cnt, a 16-bit running
// count of tick-high cycles per channel.
//
// Ports:
//   clk           single clock, rising edge
//   rst           synchronous active-high reset (highest priority)
//   soft_rst_req  restart the sequence; level sampled each edge
//   div_cfg       channel i divisor at [i*DIV_W +: DIV_W], sampled live
//   ch_rst        per-channel reset, active-high
//   tick          per-channel one-cycle tick
//   seq_done      high once all channels are released
//   state         0=HOLD, 1=RELEASE, 2=RUN
//   tick_cnt      (SEQ_TICK_CNT_EN only) channel i count at [i*16 +: 16]
module rst_clk_seq #(
  parameter int NUM_CH      = 4,
  parameter int HOLD_CYC    = 5,
  parameter int STAGGER_CYC = 2,
  parameter int DIV_W       = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    soft_rst_req,
  input  logic [NUM_CH*DIV_W-1:0] div_cfg,
  output logic [NUM_CH-1:0]       ch_rst,
  output logic [NUM_CH-1:0]       tick,
  output logic                    seq_done,
  output logic [1:0]              state
`ifdef SEQ_TICK_CNT_EN
  ,
  output logic [NUM_CH*16-1:0]    tick_cnt
`endif
);

  localparam logic [1:0] ST_HOLD    = 2'd0;
  localparam logic [1:0] ST_RELEASE = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;

  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam int SW = (STAGGER_CYC > 1) ? $clog2(STAGGER_CYC) : 1;
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
  localparam logic [SW-1:0] STAG_LAST = SW'(STAGGER_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_CH - 1);

  logic                          any_rst;
  logic [HW-1:0]                 hold_cnt;
  logic [SW-1:0]                 stag_cnt;
  logic [IW-1:0]                 rel_idx;
  logic [NUM_CH-1:0][DIV_W-1:0]  div_cnt;
  logic [NUM_CH-1:0][DIV_W-1:0]  div_cnt_nxt;
  logic [NUM_CH-1:0][DIV_W-1:0]  eff_m1;
  logic [NUM_CH-1:0]             tick_nxt;

  assign any_rst = rst | soft_rst_req;

  // Sequencer. Both counters only ever reach their *_LAST value before the
  // state moves on, so they cannot overflow.
  always_ff @(posedge clk) begin
    if (any_rst) begin
      state    <= ST_HOLD;
      ch_rst   <= '1;
      seq_done <= 1'b0;
      hold_cnt <= '0;
      stag_cnt <= '0;
      rel_idx  <= '0;
    end else begin
      case (state)
        ST_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            ch_rst[0] <= 1'b0;
            stag_cnt  <= '0;
            rel_idx   <= IW'(1);
            if (NUM_CH == 1) begin
              state    <= ST_RUN;
              seq_done <= 1'b1;
            end else begin
              state <= ST_RELEASE;
            end
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        ST_RELEASE: begin
          if (stag_cnt == STAG_LAST) begin
            stag_cnt <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
              if (rel_idx == IW'(i)) ch_rst[i] <= 1'b0;
            end
            if (rel_idx == IDX_LAST) begin
              state    <= ST_RUN;
              seq_done <= 1'b1;
            end else begin
              rel_idx <= rel_idx + IW'(1);
            end
          end else begin
            stag_cnt <= stag_cnt + SW'(1);
          end
        end
        ST_RUN:  state <= ST_RUN;
        default: state <= ST_HOLD;
      endcase
    end
  end

  // Divider next-state. The registered ch_rst is still high on a channel's
  // release edge, so its counter starts from 0 on that edge. Using >= rather
  // than == makes a lowered divisor tick on the very next edge.
  always_comb begin
    eff_m1      = '0;
    tick_nxt    = '0;
    div_cnt_nxt = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      eff_m1[i] = div_cfg[i*DIV_W +: DIV_W] -
                  ((div_cfg[i*DIV_W +: DIV_W] != '0) ? DIV_W'(1) : '0);
      if (ch_rst[i]) begin
        tick_nxt[i]    = 1'b0;
        div_cnt_nxt[i] = '0;
      end else if (div_cnt[i] >= eff_m1[i]) begin
        tick_nxt[i]    = 1'b1;
        div_cnt_nxt[i] = '0;
      end else begin
        tick_nxt[i]    = 1'b0;
        div_cnt_nxt[i] = div_cnt[i] + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (any_rst) begin
      tick    <= '0;
      div_cnt <= '0;
    end else begin
      tick    <= tick_nxt;
      div_cnt <= div_cnt_nxt;
    end
  end

`ifdef SEQ_TICK_CNT_EN
  // Counts on the same edge the tick is raised, so the field always equals
  // the number of tick-high cycles presented so far.
  logic [NUM_CH-1:0][15:0] tick_cnt_q;

  always_ff @(posedge clk) begin
    if (any_rst) begin
      tick_cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        tick_cnt_q[i] <= tick_cnt_q[i] + 16'(tick_nxt[i]);
      end
    end
  end

  assign tick_cnt = tick_cnt_q;
`endif

endmodule

// File: tb/tb_rst_clk_seq.sv
module tb_rst_clk_seq;

  localparam int NUM_CH = 4;
  localparam int H      = 5;
  localparam int S      = 2;
  localparam int DIV_W  = 8;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    soft_rst_req = 1'b0;
  logic [NUM_CH*DIV_W-1:0] div_cfg = '0;
  logic [NUM_CH-1:0]       ch_rst;
  logic [NUM_CH-1:0]       tick;
  logic                    seq_done;
  logic [1:0]              state;
`ifdef SEQ_TICK_CNT_EN
  logic [NUM_CH*16-1:0]    tick_cnt;
`endif

  rst_clk_seq #(
    .NUM_CH(NUM_CH), .HOLD_CYC(H), .STAGGER_CYC(S), .DIV_W(DIV_W)
  ) dut (
    .clk(clk), .rst(rst), .soft_rst_req(soft_rst_req), .div_cfg(div_cfg),
    .ch_rst(ch_rst), .tick(tick), .seq_done(seq_done), .state(state)
`ifdef SEQ_TICK_CNT_EN
    , .tick_cnt(tick_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          n;
    logic [3:0]  ch_rst;
    logic [3:0]  tick;
    logic        seq_done;
    logic [1:0]  state;
    bit          chk_cnt;
    logic [15:0] cnt;
  } exp_t;

  exp_t  sb[$];
  int    tests = 0;
  int    fails = 0;
  string scen = "";
  int    n = 0;
  int    div_m[NUM_CH];
  int    chg_ch = -1;
  int    chg_n  = 0;
  int    chg_d  = 1;
  bit    chk_cnt_en = 1'b0;

  // Edge-count view of the behaviour: channel i releases at edge H+i*S and
  // ticks every d edges after that; a mid-run divisor change restarts the
  // tick train at the edge of the change.
  function automatic exp_t model(int k);
    exp_t e;
    int   rel, d;
    e.name = scen; e.n = k;
    e.ch_rst = '1; e.tick = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      rel = H + i * S;
      d   = (div_m[i] == 0) ? 1 : div_m[i];
      e.ch_rst[i] = !(k >= rel);
      e.tick[i]   = (k > rel) && (((k - rel) % d) == 0);
      if (i == chg_ch && k >= chg_n) e.tick[i] = (((k - chg_n) % chg_d) == 0);
    end
    e.seq_done = (k >= H + (NUM_CH - 1) * S);
    e.state    = (k < H) ? 2'd0 : (e.seq_done ? 2'd2 : 2'd1);
    e.chk_cnt  = chk_cnt_en;
    d          = (div_m[0] == 0) ? 1 : div_m[0];
    e.cnt      = (k > H) ? 16'((k - H) / d) : 16'd0;
    return e;
  endfunction

  task automatic set_div(input int d0, input int d1, input int d2, input int d3);
    div_m[0] = d0; div_m[1] = d1; div_m[2] = d2; div_m[3] = d3;
    for (int i = 0; i < NUM_CH; i++) div_cfg[i*DIV_W +: DIV_W] = DIV_W'(div_m[i]);
  endtask

  task automatic edge_run(input bit r, input bit s);
    @(negedge clk);
    rst = r; soft_rst_req = s;
    @(posedge clk);
    #1;
    if (r || s) n = 0; else n = n + 1;
    sb.push_back(model(n));
  endtask

  task automatic run(input int k);
    repeat (k) edge_run(1'b0, 1'b0);
  endtask

  // Monitor: outputs are presented every cycle, checked away from the edge.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      tests++;
      if (ch_rst !== e.ch_rst) begin
        fails++;
        $display("FAIL %s edge %0d ch_rst got %h want %h", e.name, e.n, ch_rst, e.ch_rst);
      end
      tests++;
      if (tick !== e.tick) begin
        fails++;
        $display("FAIL %s edge %0d tick got %h want %h", e.name, e.n, tick, e.tick);
      end
      tests++;
      if (seq_done !== e.seq_done) begin
        fails++;
        $display("FAIL %s edge %0d seq_done got %b want %b", e.name, e.n, seq_done, e.seq_done);
      end
      tests++;
      if (state !== e.state) begin
        fails++;
        $display("FAIL %s edge %0d state got %0d want %0d", e.name, e.n, state, e.state);
      end
`ifdef SEQ_TICK_CNT_EN
      if (e.chk_cnt) begin
        tests++;
        if (tick_cnt[15:0] !== e.cnt) begin
          fails++;
          $display("FAIL %s edge %0d tick_cnt0 got %0d want %0d", e.name, e.n, tick_cnt[15:0], e.cnt);
        end
      end
`endif
    end
  end

  initial begin
    // 1: reset held 3 cycles, staggered release with all divisors 2
    scen = "s1_defaults";
    set_div(2, 2, 2, 2);
    repeat (3) edge_run(1'b1, 1'b0);
    run(14);

    // 2: ch0 divides by 3, ch1 divisor 0 ticks every cycle
    scen = "s2_divs";
    set_div(3, 0, 2, 2);
    edge_run(1'b1, 1'b0);
    run(16);

    // 3: one-cycle soft reset from RUN, then a fresh sequence
    scen = "s3_soft";
    edge_run(1'b0, 1'b1);
    run(8);

    // 4: rst mid-RELEASE, then rst with soft_rst_req together from RUN
    scen = "s4_mid_rel";
    set_div(2, 2, 2, 2);
    edge_run(1'b1, 1'b0);
    run(6);
    edge_run(1'b1, 1'b0);
    run(14);
    scen = "s4_both";
    edge_run(1'b1, 1'b1);
    run(14);

    // 5: ch2 divisor 10 lowered to 2 while its counter sits at 6
    scen = "s5_lower";
    set_div(2, 2, 10, 2);
    edge_run(1'b1, 1'b0);
    run(15);
    chg_ch = 2; chg_n = 16; chg_d = 2;
    set_div(2, 2, 2, 2);
    run(6);
    chg_ch = -1;

`ifdef SEQ_TICK_CNT_EN
    // 6: tick counter, then a full 16-bit wrap at divisor 1
    scen = "s6_cnt";
    chk_cnt_en = 1'b1;
    set_div(2, 2, 2, 2);
    edge_run(1'b1, 1'b0);
    run(13);
    scen = "s6_wrap";
    set_div(1, 2, 2, 2);
    edge_run(1'b1, 1'b0);
    run(H + 65536 + 2);
    chk_cnt_en = 1'b0;
`endif

    repeat (2) @(negedge clk);
    #1;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain pending got %0d want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rst_clk_seq.md
Name: rst_clk_seq

Overview:
Synthesizable, parametrised reset sequencer and tick generator. After a hold period it releases NUM_CH channel resets in staggered order. Each released channel then produces a one-cycle tick at a programmable divide ratio. It sits at the top of each subsystem, drives per-channel resets and clock enables, and replaces ad-hoc bench reset and clock tasks with one reusable block.

Parameters:
NUM_CH, 4, number of reset/tick channels (>=1)
HOLD_CYC, 5, cycles all channel resets stay asserted after rst/soft reset (>=1)
STAGGER_CYC, 2, cycles between consecutive channel releases (>=1)
DIV_W, 8, width of each channel divisor

Ports:
clk  in  1  single clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
soft_rst_req  in  1  restart sequence; level sampled each edge
div_cfg  in  NUM_CH*DIV_W  channel i divisor at [i*DIV_W +: DIV_W]; sampled live
ch_rst  out  NUM_CH  per-channel reset, active-high
tick  out  NUM_CH  per-channel one-cycle tick
seq_done  out  1  high once all channels are released
state  out  2  FSM state: HOLD=0, RELEASE=1, RUN=2

Behaviour:
- All outputs are registered.
- rst=1 at an edge: state=HOLD, ch_rst all 1, tick all 0, seq_done=0, hold/stagger/divider counters=0.
- Priority: rst > soft_rst_req > normal operation.
- Edge numbering: edge 1 is the first edge with rst=0.
- HOLD: hold counter increments each edge.
  - At edge HOLD_CYC: state->RELEASE and ch_rst[0]=0.
  - If NUM_CH==1: state->RUN and seq_done=1 on that same edge.
- RELEASE: ch_rst[i]=0 at edge HOLD_CYC+i*STAGGER_CYC.
  - On the edge that releases channel NUM_CH-1: state->RUN, seq_done=1.
  - Defaults: channels release at edges 5, 7, 9, 11; seq_done=1 at edge 11.
- RUN: steady state. Stays in RUN until rst or soft_rst_req.
- Divider, channel i:
  - eff_div = max(div_cfg_i, 1).
  - Counter is 0 on the release edge and increments each edge while ch_rst[i]=0.
  - At an edge where counter >= eff_div-1: counter->0 and tick[i]=1. Otherwise tick[i]=0.
  - First tick is high after edge release+eff_div; period is eff_div cycles.
  - eff_div=1 holds tick high continuously.
  - Lowering div_cfg below the current count gives a tick on the next edge, then the new period.
  - A channel still in reset never ticks.
- soft_rst_req=1 at an edge (rst=0): same effect as rst; the sequence restarts from HOLD counter 0. Held high, it keeps the block in HOLD.
- rst or soft reset mid-RELEASE or mid-RUN: all outputs return to reset values on that edge. No partial release survives.
- Counters are sized for their parameters; no overflow is possible in the hold or stagger counters.

Optional Feature:
SEQ_TICK_CNT_EN
- Defined: adds output port tick_cnt, NUM_CH*16 bits, channel i at [i*16 +: 16].
  - Each field increments on every edge where tick[i] is set, so it reads equal to the number of tick-high cycles seen.
  - Cleared by rst and soft_rst_req; wraps 16'hFFFF -> 0.
- Undefined: the port is absent and no counter logic is generated.

Test Plan:
1. Defaults, rst high 3 cycles then low, div_cfg all 2 -> ch_rst clears at edges 5/7/9/11; seq_done=1 and state=2 at edge 11; state=1 from edge 5 to 10.
2. div_cfg ch0=3, ch1=0 -> tick[0] high after edges 8, 11, 14; tick[1] high continuously from edge 8; tick never high while ch_rst=1.
3. In RUN, pulse soft_rst_req 1 cycle -> next edge ch_rst=4'hF, tick=0, seq_done=0, state=0; ch_rst[0] clears 5 edges later.
4. rst asserted after ch_rst[0] cleared (mid-RELEASE), and separately rst+soft_rst_req together -> all outputs at reset values on that edge; restart identical to scenario 1.
5. ch2 div_cfg=10; when its counter=6, change to 2 -> tick[2] on next edge, then every 2 cycles.
6. SEQ_TICK_CNT_EN defined, ch0 div=2 -> tick_cnt[15:0]=4 after four tick-high cycles; ch0 div=1 for 65536 tick-high cycles -> field wraps to 0.
